// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding for the load/store sequencer
package mem_pkg;

   localparam int unsigned NUM_STATES  = 7;
   localparam int unsigned STATE_WIDTH = 3;

   typedef enum logic [STATE_WIDTH-1:0] {
      S_IDLE     = 3'd0,
      S_LOOKUP   = 3'd1,
      S_MEM_RD   = 3'd2,
      S_FILL     = 3'd3,
      S_MEM_WR   = 3'd4,
      S_CACHE_WR = 3'd5,
      S_DONE     = 3'd6
   } state_t;

endpackage

// File: rtl/mem_ctrl_sat_counter.sv
// rtl/mem_ctrl_sat_counter.sv - saturating event counter
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear has priority, increment stops at all-ones.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - CPU load/store sequencer over a write-through cache and byte memory
module mem_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 15,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   output logic                  cpu_err,
   output logic                  busy,
   output logic                  c_req,
   output logic                  c_we,
   output logic [ADDR_WIDTH-1:0] c_addr,
   output logic [DATA_WIDTH-1:0] c_wdata,
   input  logic [DATA_WIDTH-1:0] c_rdata,
   input  logic                  c_hit,
   output logic                  mem_valid,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic [CNT_WIDTH-1:0]  hit_cnt,
   output logic [CNT_WIDTH-1:0]  miss_cnt
);

   // The wait counter only needs to reach TIMEOUT-1: the cycle that would
   // make it TIMEOUT is the abort cycle itself.
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic                  hit_inc;
   logic                  miss_inc;
   logic                  wait_last;

   assign wait_last = (wait_q == WAIT_LAST);

   // State and latched request/response registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state logic: request capture, lookup outcome, memory wait with abort.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      wait_d   = wait_q;
      hit_inc  = 1'b0;
      miss_inc = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               wait_d  = '0;
               state_d = cpu_we ? S_MEM_WR : S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (c_hit) begin
               rdata_d = c_rdata;
               hit_inc = 1'b1;
               state_d = S_DONE;
            end else begin
               miss_inc = 1'b1;
               wait_d   = '0;
               state_d  = S_MEM_RD;
            end
         end
         S_MEM_RD: begin
            if (mem_ready) begin
               rdata_d = mem_rdata;
               state_d = S_FILL;
            end else if (wait_last) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
            end
         end
         S_FILL: begin
            state_d = S_DONE;
         end
         S_MEM_WR: begin
            if (mem_ready) begin
               state_d = S_CACHE_WR;
            end else if (wait_last) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
            end
         end
         S_CACHE_WR: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the current state only; idle buses read as zero.
   always_comb begin
      cpu_rdata = '0;
      cpu_ready = 1'b0;
      cpu_err   = 1'b0;
      busy      = (state_q != S_IDLE);
      c_req     = 1'b0;
      c_we      = 1'b0;
      c_addr    = '0;
      c_wdata   = '0;
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         S_LOOKUP: begin
            c_req  = 1'b1;
            c_addr = addr_q;
         end
         S_MEM_RD: begin
            mem_valid = 1'b1;
            mem_addr  = addr_q;
         end
         S_FILL: begin
            c_we    = 1'b1;
            c_addr  = addr_q;
            c_wdata = rdata_q;
         end
         S_MEM_WR: begin
            mem_valid = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
         end
         S_CACHE_WR: begin
            c_we    = 1'b1;
            c_addr  = addr_q;
            c_wdata = wdata_q;
         end
         S_DONE: begin
            cpu_ready = 1'b1;
            cpu_err   = err_q;
            cpu_rdata = rdata_q;
         end
         default: begin
         end
      endcase
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (1'b0),
      .inc_i   (hit_inc),
      .count_o (hit_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (1'b0),
      .inc_i   (miss_inc),
      .count_o (miss_cnt)
   );

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl against a transaction-level model
module tb_mem_ctrl;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 4;
   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ready;
   logic          cpu_err;
   logic          busy;
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic [DW-1:0] c_rdata;
   logic          c_hit;
   logic          mem_valid;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic [CW-1:0] hit_cnt;
   logic [CW-1:0] miss_cnt;

   mem_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_err   (cpu_err),
      .busy      (busy),
      .c_req     (c_req),
      .c_we      (c_we),
      .c_addr    (c_addr),
      .c_wdata   (c_wdata),
      .c_rdata   (c_rdata),
      .c_hit     (c_hit),
      .mem_valid (mem_valid),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic          err;
      logic          fill;
      logic [DW-1:0] fill_data;
      int            lat;
      int            issue;
      int            hit;
      int            miss;
   } exp_t;

   exp_t sbq[$];

   // Environment: external cache contents and slow memory, owned by one process.
   logic          env_cv [256];
   logic [DW-1:0] env_cd [256];
   logic [DW-1:0] env_mem[256];
   int            resp_wait = 1;

   assign c_hit   = env_cv[c_addr];
   assign c_rdata = env_cd[c_addr];

   initial begin : env
      int wcnt;
      wcnt = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < 256; i++) begin
         env_cv[i]  = 1'b0;
         env_cd[i]  = 8'(i * 13 + 1);
         env_mem[i] = 8'(i * 29 + 7);
      end
      env_cv[8'h10]  = 1'b1;
      env_cd[8'h10]  = 8'hAB;
      env_mem[8'h20] = 8'h5C;
      forever begin
         @(posedge clk);
         if (rst && mem_valid && mem_ready && mem_we) env_mem[mem_addr] = mem_wdata;
         if (rst && c_we) begin
            env_cv[c_addr] = 1'b1;
            env_cd[c_addr] = c_wdata;
         end
         @(negedge clk);
         if (mem_valid) begin
            wcnt++;
            mem_ready = (wcnt == resp_wait);
            mem_rdata = mem_ready ? env_mem[mem_addr] : 8'($urandom);
         end else begin
            wcnt = 0;
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = 8'($urandom);
         end
      end
   end

   // Monitor: protocol checks every cycle, response checks on each completion.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("strobe_exclusive", {30'b0, c_req & c_we, mem_valid & (c_req | c_we)}, 0);
            if (sbq.size() == 0) begin
               check("idle_no_cache_strobe", {31'b0, c_req | c_we}, 0);
               check("idle_no_mem_valid", {31'b0, mem_valid}, 0);
               check("spurious_ready", {31'b0, cpu_ready}, 0);
            end else begin
               e = sbq[0];
               if (c_req) begin
                  check("lookup_only_for_load", {31'b0, e.we}, 0);
                  check("lookup_addr", c_addr, e.addr);
               end
               if (c_we) begin
                  check("cache_write_allowed", {31'b0, e.fill}, 1);
                  check("cache_write_addr", c_addr, e.addr);
                  check("cache_write_data", c_wdata, e.fill_data);
               end
               if (mem_valid) begin
                  check("mem_addr", mem_addr, e.addr);
                  check("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                  if (e.we) check("mem_wdata", mem_wdata, e.wdata);
               end
               if (cpu_ready) begin
                  void'(sbq.pop_front());
                  check("rdata", cpu_rdata, e.rdata);
                  check("err", {31'b0, cpu_err}, {31'b0, e.err});
                  check("latency", cyc - e.issue + 1, e.lat);
                  check("hit_cnt", hit_cnt, e.hit);
                  check("miss_cnt", miss_cnt, e.miss);
               end
            end
         end
      end
   end

   // Reference model: what each transaction must return, from address state alone.
   logic          ref_cv [256];
   logic [DW-1:0] ref_cd [256];
   logic [DW-1:0] ref_mem[256];
   int            ref_hit  = 0;
   int            ref_miss = 0;

   function automatic int sat_inc(input int v);
      return (v < CMAX) ? v + 1 : v;
   endfunction

   // Called at a negedge with the DUT idle: predict, queue, and present one request.
   task automatic start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int w);
      exp_t e;
      bit   to;
      to = (w == 0) || (w > TO);
      e.we = we; e.addr = a; e.wdata = d; e.rdata = '0; e.err = 1'b0;
      e.fill = 1'b0; e.fill_data = '0;
      if (!we) begin
         if (ref_cv[a]) begin
            e.rdata = ref_cd[a];
            ref_hit = sat_inc(ref_hit);
            e.lat = 2;
         end else begin
            ref_miss = sat_inc(ref_miss);
            if (to) begin
               e.err = 1'b1;
               e.lat = 2 + TO;
            end else begin
               e.rdata = ref_mem[a];
               e.fill = 1'b1;
               e.fill_data = ref_mem[a];
               ref_cv[a] = 1'b1;
               ref_cd[a] = ref_mem[a];
               e.lat = 3 + w;
            end
         end
      end else begin
         if (to) begin
            e.err = 1'b1;
            e.lat = 1 + TO;
         end else begin
            ref_mem[a] = d;
            ref_cv[a] = 1'b1;
            ref_cd[a] = d;
            e.fill = 1'b1;
            e.fill_data = d;
            e.lat = 2 + w;
         end
      end
      e.hit = ref_hit;
      e.miss = ref_miss;
      e.issue = cyc + 1;
      resp_wait = w;
      sbq.push_back(e);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      @(negedge clk);
      cpu_req = 1'b0;
   endtask

   // Wait for completion while throwing stray request pulses at the busy DUT.
   task automatic finish_wait();
      int n;
      n = 0;
      while (busy && n < 100) begin
         cpu_req = 1'($urandom_range(0, 1));
         cpu_we = 1'($urandom_range(0, 1));
         cpu_addr = 8'($urandom);
         cpu_wdata = 8'($urandom);
         @(negedge clk);
         n++;
      end
      cpu_req = 1'b0;
      if (n >= 100) check("completion_within_budget", {31'b0, busy}, 0);
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int w);
      start(we, a, d, w);
      finish_wait();
   endtask

   initial begin : stim
      int n;
      rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         ref_cv[i]  = 1'b0;
         ref_mem[i] = 8'(i * 29 + 7);
         ref_cd[i]  = '0;
      end
      ref_cv[8'h10]  = 1'b1;
      ref_cd[8'h10]  = 8'hAB;
      ref_mem[8'h20] = 8'h5C;

      repeat (3) @(negedge clk);
      check("rst_cpu_ready", {31'b0, cpu_ready}, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_cpu_err", {31'b0, cpu_err}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_c_req", {31'b0, c_req}, 0);
      check("rst_c_we", {31'b0, c_we}, 0);
      check("rst_c_addr", c_addr, 0);
      check("rst_c_wdata", c_wdata, 0);
      check("rst_mem_valid", {31'b0, mem_valid}, 0);
      check("rst_mem_we", {31'b0, mem_we}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_hit_cnt", hit_cnt, 0);
      check("rst_miss_cnt", miss_cnt, 0);
      rst = 1'b1;
      @(negedge clk);

      issue(1'b0, 8'h10, 8'h00, 1);   // preloaded hit
      issue(1'b0, 8'h20, 8'h00, 3);   // miss, W=3
      issue(1'b0, 8'h20, 8'h00, 1);   // now a hit
      issue(1'b1, 8'h30, 8'h77, 1);   // store, W=1
      issue(1'b0, 8'h30, 8'h00, 1);   // store updated the cache
      issue(1'b0, 8'h40, 8'h00, 0);   // load timeout
      issue(1'b0, 8'h41, 8'h00, TO);  // ready on the last permitted cycle
      issue(1'b1, 8'h50, 8'h12, 0);   // store timeout
      issue(1'b1, 8'h51, 8'h34, TO);

      // Reset while waiting in MEM_RD.
      start(1'b0, 8'h60, 8'h00, 0);
      n = 0;
      while (!mem_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("reached_mem_rd", {31'b0, mem_valid}, 1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      sbq.delete();
      ref_hit = 0;
      ref_miss = 0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_busy", {31'b0, busy}, 0);
      check("midrst_mem_valid", {31'b0, mem_valid}, 0);
      check("midrst_cpu_ready", {31'b0, cpu_ready}, 0);
      check("midrst_c_we", {31'b0, c_we}, 0);
      check("midrst_hit_cnt", hit_cnt, 0);
      check("midrst_miss_cnt", miss_cnt, 0);
      rst = 1'b1;
      @(negedge clk);
      issue(1'b0, 8'h61, 8'h00, 2);

      // Drive the hit counter into saturation.
      repeat (5) issue(1'b0, 8'h10, 8'h00, 1);

      for (int t = 0; t < 200; t++) begin
         issue(1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 31)), 8'($urandom),
               $urandom_range(0, 6));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
